// File: rtl/ppi_bus_master_if.sv
// Command/response handshake between a host and the 8255 PPI bus master.
// The host side uses the master modport; the bus master uses the slave modport.
interface ppi_bus_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [1:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_err;
   logic [7:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_data,
      input  cmd_ready, rsp_valid, rsp_err, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data,
      output cmd_ready, rsp_valid, rsp_err, rsp_data
   );
endinterface

// File: rtl/ppi_bus_master.sv
// Host-side initiator for the 8255A PPI bus: runs timed port read/write,
// control-word, BSR and PPI-reset cycles for single commands, reports
// completion, and shadows the last mode-set control word.
module ppi_bus_master #(
   parameter int unsigned T_SETUP  = 1,
   parameter int unsigned T_STROBE = 2,
   parameter int unsigned T_HOLD   = 1,
   parameter int unsigned PRST_CYC = 4
) (
   input  logic             clk,
   input  logic             Reset,
   ppi_bus_master_if.slave  cmd,
   output logic [5:0]       control,
   inout  wire  [7:0]       PD,
   output logic [7:0]       ctrl_shadow
);

   localparam logic [5:0] CTRL_IDLE = 6'b111000;
   localparam logic [5:0] CTRL_PRST = 6'b111100;

   typedef enum logic [2:0] {
      IDLE, SETUP, STROBE, HOLD, PRST, RESP
   } state_t;

   typedef enum logic [2:0] {
      OP_WR_PORT = 3'b000,
      OP_RD_PORT = 3'b001,
      OP_WR_CTRL = 3'b010,
      OP_BSR     = 3'b011,
      OP_PPI_RST = 3'b100
   } op_t;

   state_t     state;
   logic [7:0] cnt;
   logic       rd_op;
   logic       ctrl_op;
   logic [1:0] addr;
   logic [7:0] wr_data;
   logic       pd_oe;
   logic       illegal;
   logic       port_op;

   // Classify the offered command; illegal ones complete with an error and no bus cycle.
   always_comb begin
      port_op = (cmd.cmd_op == OP_WR_PORT) || (cmd.cmd_op == OP_RD_PORT);
      illegal = 1'b0;
      if (cmd.cmd_op > OP_PPI_RST)
         illegal = 1'b1;
      else if (port_op && (cmd.cmd_addr == 2'b11))
         illegal = 1'b1;
      else if ((cmd.cmd_op == OP_WR_CTRL) && !cmd.cmd_data[7])
         illegal = 1'b1;
   end

   // Write data is driven only while a write bus cycle is in progress.
   assign PD = pd_oe ? wr_data : 'z;

   // Bus-cycle sequencer with registered control vector, data enable and response.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         cnt           <= '0;
         rd_op         <= 1'b0;
         ctrl_op       <= 1'b0;
         addr          <= '0;
         wr_data       <= '0;
         pd_oe         <= 1'b0;
         control       <= CTRL_IDLE;
         cmd.cmd_ready <= 1'b1;
         cmd.rsp_valid <= 1'b0;
         cmd.rsp_err   <= 1'b0;
         cmd.rsp_data  <= '0;
         ctrl_shadow   <= 8'h9B;
      end else begin
         cmd.rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd.cmd_valid) begin
                  cmd.cmd_ready <= 1'b0;
                  cmd.rsp_data  <= '0;
                  cmd.rsp_err   <= 1'b0;
                  ctrl_op       <= (cmd.cmd_op == OP_WR_CTRL);
                  rd_op         <= (cmd.cmd_op == OP_RD_PORT);
                  if (illegal) begin
                     state         <= RESP;
                     cmd.rsp_valid <= 1'b1;
                     cmd.rsp_err   <= 1'b1;
                  end else if (cmd.cmd_op == OP_PPI_RST) begin
                     state   <= PRST;
                     cnt     <= 8'(PRST_CYC - 1);
                     control <= CTRL_PRST;
                  end else begin
                     state   <= SETUP;
                     cnt     <= 8'(T_SETUP - 1);
                     addr    <= port_op ? cmd.cmd_addr : 2'b11;
                     wr_data <= (cmd.cmd_op == OP_BSR) ? {4'b0000, cmd.cmd_data[3:0]}
                                                       : cmd.cmd_data;
                     control <= {4'b0110, port_op ? cmd.cmd_addr : 2'b11};
                     pd_oe   <= (cmd.cmd_op != OP_RD_PORT);
                  end
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  state   <= STROBE;
                  cnt     <= 8'(T_STROBE - 1);
                  control <= rd_op ? {4'b0010, addr} : {4'b0100, addr};
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            STROBE: begin
               if (cnt == '0) begin
                  state   <= HOLD;
                  cnt     <= 8'(T_HOLD - 1);
                  control <= {4'b0110, addr};
                  // Read data is captured on the edge where nRe rises.
                  if (rd_op)
                     cmd.rsp_data <= PD;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  state         <= RESP;
                  control       <= CTRL_IDLE;
                  pd_oe         <= 1'b0;
                  cmd.rsp_valid <= 1'b1;
                  if (ctrl_op)
                     ctrl_shadow <= wr_data;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            PRST: begin
               if (cnt == '0) begin
                  state         <= RESP;
                  control       <= CTRL_IDLE;
                  cmd.rsp_valid <= 1'b1;
                  ctrl_shadow   <= 8'h9B;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            RESP: begin
               state         <= IDLE;
               cmd.cmd_ready <= 1'b1;
               cmd.rsp_err   <= 1'b0;
            end
            default: begin
               state         <= IDLE;
               control       <= CTRL_IDLE;
               pd_oe         <= 1'b0;
               cmd.cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed self-checking bench for ppi_bus_master at default timing.
module tb_ppi_bus_master;

   logic       clk;
   logic       Reset;
   logic [5:0] control;
   logic [7:0] ctrl_shadow;
   wire  [7:0] PD;
   logic       tb_pd_en;
   logic [7:0] tb_pd;
   int         nchk;
   int         nerr;

   ppi_bus_master_if bus ();

   ppi_bus_master #(
      .T_SETUP (1),
      .T_STROBE(2),
      .T_HOLD  (1),
      .PRST_CYC(4)
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .cmd        (bus),
      .control    (control),
      .PD         (PD),
      .ctrl_shadow(ctrl_shadow)
   );

   // External PPI model driving the data bus for reads / release checks.
   assign PD = tb_pd_en ? tb_pd : 'z;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a command at a falling edge; it is accepted on the next rising edge.
   task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      chk("cmd_ready_before_accept", 8'(bus.cmd_ready), 8'h01);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = a;
      bus.cmd_data  = d;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   // Full bus cycle: cycles 1 and 4 setup/hold, 2-3 strobe, response in cycle 5.
   task automatic run_bus(input string name, input logic [2:0] op, input logic [1:0] a,
                          input logic [7:0] d, input logic [5:0] c_sh, input logic [5:0] c_st,
                          input logic pd_chk, input logic [7:0] pd_exp,
                          input logic [7:0] rd_exp, input logic [7:0] sh_exp);
      issue(op, a, d);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk({name, "_control"}, 8'(control), 8'((k == 1 || k == 4) ? c_sh : c_st));
         chk({name, "_rsp_valid_low"}, 8'(bus.rsp_valid), 8'h00);
         if (pd_chk)
            chk({name, "_pd"}, PD, pd_exp);
      end
      @(negedge clk);
      chk({name, "_rsp_valid"}, 8'(bus.rsp_valid), 8'h01);
      chk({name, "_rsp_err"}, 8'(bus.rsp_err), 8'h00);
      chk({name, "_rsp_data"}, bus.rsp_data, rd_exp);
      chk({name, "_resp_control"}, 8'(control), 8'h38);
      chk({name, "_shadow"}, ctrl_shadow, sh_exp);
      @(negedge clk);
      chk({name, "_ready_after"}, 8'(bus.cmd_ready), 8'h01);
      chk({name, "_rsp_valid_drop"}, 8'(bus.rsp_valid), 8'h00);
      chk({name, "_idle_control"}, 8'(control), 8'h38);
   endtask

   task automatic run_illegal(input string name, input logic [2:0] op, input logic [1:0] a,
                              input logic [7:0] d);
      issue(op, a, d);
      @(negedge clk);
      chk({name, "_rsp_valid"}, 8'(bus.rsp_valid), 8'h01);
      chk({name, "_rsp_err"}, 8'(bus.rsp_err), 8'h01);
      chk({name, "_control"}, 8'(control), 8'h38);
      @(negedge clk);
      chk({name, "_rsp_valid_drop"}, 8'(bus.rsp_valid), 8'h00);
      chk({name, "_ready"}, 8'(bus.cmd_ready), 8'h01);
      chk({name, "_control_idle"}, 8'(control), 8'h38);
   endtask

   initial begin
      nchk          = 0;
      nerr          = 0;
      Reset         = 1'b1;
      tb_pd_en      = 1'b0;
      tb_pd         = 8'h00;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'b000;
      bus.cmd_addr  = 2'b00;
      bus.cmd_data  = 8'h00;

      // Reset state, including data bus released
      repeat (2) @(negedge clk);
      tb_pd_en = 1'b1;
      tb_pd    = 8'h3C;
      #1;
      chk("rst_control", 8'(control), 8'h38);
      chk("rst_ready", 8'(bus.cmd_ready), 8'h01);
      chk("rst_rsp_valid", 8'(bus.rsp_valid), 8'h00);
      chk("rst_rsp_err", 8'(bus.rsp_err), 8'h00);
      chk("rst_rsp_data", bus.rsp_data, 8'h00);
      chk("rst_shadow", ctrl_shadow, 8'h9B);
      chk("rst_pd_released", PD, 8'h3C);
      tb_pd_en = 1'b0;
      Reset    = 1'b0;

      // Control word write: A=11
      run_bus("wr_ctrl", 3'b010, 2'b00, 8'h80, 6'b011011, 6'b010011, 1'b1, 8'h80, 8'h00, 8'h80);

      // Port B read with external model driving A5
      tb_pd_en = 1'b1;
      tb_pd    = 8'hA5;
      run_bus("rd_port", 3'b001, 2'b01, 8'h5A, 6'b011001, 6'b001001, 1'b1, 8'hA5, 8'hA5, 8'h80);
      tb_pd    = 8'h3C;
      #1 chk("rd_pd_released_idle", PD, 8'h3C);
      tb_pd_en = 1'b0;

      // BSR bit 5 set, and a BSR with upper bits that must be masked
      run_bus("bsr_0b", 3'b011, 2'b00, 8'h0B, 6'b011011, 6'b010011, 1'b1, 8'h0B, 8'h00, 8'h80);
      run_bus("bsr_f6", 3'b011, 2'b10, 8'hF6, 6'b011011, 6'b010011, 1'b1, 8'h06, 8'h00, 8'h80);

      // Port C write
      run_bus("wr_port", 3'b000, 2'b10, 8'h3C, 6'b011010, 6'b010010, 1'b1, 8'h3C, 8'h00, 8'h80);

      // Illegal commands
      run_illegal("ill_op6", 3'b110, 2'b00, 8'h00);
      run_illegal("ill_rd_a3", 3'b001, 2'b11, 8'h00);
      run_illegal("ill_wr_a3", 3'b000, 2'b11, 8'h55);
      run_illegal("ill_ctrl", 3'b010, 2'b00, 8'h12);
      chk("ill_shadow_kept", ctrl_shadow, 8'h80);

      // PPI reset pulse
      issue(3'b100, 2'b00, 8'h00);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("prst_control", 8'(control), 8'h3C);
         chk("prst_rsp_valid_low", 8'(bus.rsp_valid), 8'h00);
      end
      @(negedge clk);
      chk("prst_rsp_valid", 8'(bus.rsp_valid), 8'h01);
      chk("prst_rsp_err", 8'(bus.rsp_err), 8'h00);
      chk("prst_end_control", 8'(control), 8'h38);
      chk("prst_shadow", ctrl_shadow, 8'h9B);

      // Reset asserted during the strobe of a write
      issue(3'b000, 2'b00, 8'hA5);
      @(negedge clk);
      @(negedge clk);
      chk("midrst_strobe_control", 8'(control), 8'h10);
      chk("midrst_strobe_pd", PD, 8'hA5);
      Reset = 1'b1;
      #1;
      chk("midrst_control", 8'(control), 8'h38);
      chk("midrst_rsp_valid", 8'(bus.rsp_valid), 8'h00);
      chk("midrst_ready", 8'(bus.cmd_ready), 8'h01);
      tb_pd_en = 1'b1;
      tb_pd    = 8'h5A;
      #1 chk("midrst_pd_released", PD, 8'h5A);
      tb_pd_en = 1'b0;
      @(negedge clk);
      Reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("midrst_no_rsp", 8'(bus.rsp_valid), 8'h00);
         chk("midrst_idle_control", 8'(control), 8'h38);
      end

      // Next command after reset runs normally; shadow back to reset value
      run_bus("post_rst", 3'b000, 2'b01, 8'hC3, 6'b011001, 6'b010001, 1'b1, 8'hC3, 8'h00, 8'h9B);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
      $finish;
   end

endmodule
